instr_mem: RTL and testbench

Word-addressed, single-port instruction memory for the processor's fetch stage. During setup/program-load it accepts writes of instruction words from the `setup` bus; during execution it returns the word at `address` on `instruction` through a registered, one-cycle read. Memory contents survive reset; only the output register is reset.

---
 rtl/instr_mem_pkg.sv | 19 +
 rtl/instr_mem_array.sv | 31 +++
 rtl/instr_mem.sv | 68 ++++++
 tb/tb_instr_mem.sv | 130 +++++++++++++
 4 files changed

// File: rtl/instr_mem_pkg.sv
// Shared constants for the fetch-stage instruction memory.
package instr_mem_pkg;

    // Instruction word width and implemented address space.
    localparam int DATA_WIDTH = 16;
    localparam int ADDR_BITS  = 8;
    localparam int DEPTH      = 1 << ADDR_BITS;

    // Width of the address bus presented by the fetch stage.
    localparam int ADDR_WIDTH = 16;

    // R_WR encoding.
    localparam logic MODE_WRITE = 1'b0;
    localparam logic MODE_READ  = 1'b1;

    // enable is active-low.
    localparam logic EN_ACTIVE  = 1'b0;

endpackage : instr_mem_pkg

// File: rtl/instr_mem_array.sv
// Plain single-port RAM: synchronous write, combinational read port.
// No reset; contents start at zero and persist across system reset.
module instr_mem_array
    import instr_mem_pkg::*;
#(
    parameter int WORD_W = instr_mem_pkg::DATA_WIDTH,
    parameter int ABITS  = instr_mem_pkg::ADDR_BITS
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ABITS-1:0]  addr,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata
);

    localparam int WORDS = 1 << ABITS;

    // Storage; power-up contents are all zero.
    logic [WORD_W-1:0] mem_q [WORDS] = '{default: '0};

    // Store the write word on the rising edge when the write strobe is set.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[addr] <= wdata;
        end
    end

    // The top-level output register captures this value, giving a one-cycle read.
    assign rdata = mem_q[addr];

endmodule : instr_mem_array

// File: rtl/instr_mem.sv
// Fetch-stage instruction memory: range check, enable/mode decode and the
// registered, resettable instruction output around a plain RAM.
module instr_mem
    import instr_mem_pkg::*;
#(
    parameter int DATA_WIDTH = instr_mem_pkg::DATA_WIDTH,
    parameter int ADDR_BITS  = instr_mem_pkg::ADDR_BITS
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [15:0]           address,
    input  logic [DATA_WIDTH-1:0] setup,
    input  logic                  R_WR,
    input  logic                  enable,
    output logic [DATA_WIDTH-1:0] instruction
);

    logic                  in_range;
    logic                  active;
    logic                  do_write;
    logic                  do_read;
    logic                  mem_we;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic [DATA_WIDTH-1:0] instr_d;
    logic [DATA_WIDTH-1:0] instr_q;

    // Any address bit above the implemented range makes the access out of range.
    assign in_range = ((address >> ADDR_BITS) == 16'd0);

    // Decode the active-low enable and the read/write mode.
    assign active   = (enable == EN_ACTIVE);
    assign do_write = active && (R_WR == MODE_WRITE);
    assign do_read  = active && (R_WR == MODE_READ);

    // Reset suppresses writes; out-of-range writes are dropped rather than aliased.
    assign mem_we = !reset && do_write && in_range;

    instr_mem_array #(
        .WORD_W (DATA_WIDTH),
        .ABITS  (ADDR_BITS)
    ) u_array (
        .clk   (clk),
        .we    (mem_we),
        .addr  (address[ADDR_BITS-1:0]),
        .wdata (setup),
        .rdata (mem_rdata)
    );

    // Next output: new word on an in-range read, zero on an out-of-range read, else hold.
    always_comb begin
        instr_d = instr_q;
        if (do_read) begin
            instr_d = in_range ? mem_rdata : '0;
        end
    end

    // Output register; reset clears it but never touches memory contents.
    always_ff @(posedge clk) begin
        if (reset) begin
            instr_q <= '0;
        end else begin
            instr_q <= instr_d;
        end
    end

    assign instruction = instr_q;

endmodule : instr_mem

// File: tb/tb_instr_mem.sv
// Directed self-checking bench for instr_mem.
module tb_instr_mem;

    logic        clk;
    logic        reset;
    logic [15:0] address;
    logic [15:0] setup;
    logic        R_WR;
    logic        enable;
    logic [15:0] instruction;

    int pass_cnt;
    int total_cnt;

    instr_mem dut (
        .clk         (clk),
        .reset       (reset),
        .address     (address),
        .setup       (setup),
        .R_WR        (R_WR),
        .enable      (enable),
        .instruction (instruction)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply inputs, let one rising edge pass, then settle 1 time unit.
    task automatic step(input logic rst, input logic rw, input logic en,
                        input logic [15:0] a, input logic [15:0] d);
        reset   = rst;
        R_WR    = rw;
        enable  = en;
        address = a;
        setup   = d;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] exp);
        total_cnt++;
        assert (instruction === exp) begin
            pass_cnt++;
        end else begin
            $error("FAIL %s: instruction=%h expected=%h", tag, instruction, exp);
        end
    endtask

    initial begin
        logic [15:0] wa [12];
        logic [15:0] wd [12];
        pass_cnt  = 0;
        total_cnt = 0;
        wa = '{16'd0, 16'd10, 16'd20, 16'd30, 16'd40, 16'd50,
               16'd60, 16'd70, 16'd80, 16'd90, 16'd100, 16'd200};
        wd = '{16'd12, 16'd34, 16'd56, 16'd78, 16'd90, 16'd1234,
               16'd5678, 16'd1234, 16'd5678, 16'd12345, 16'd50123, 16'd9012};

        reset = 1'b1; R_WR = 1'b1; enable = 1'b0; address = 16'd0; setup = 16'd0;
        #2;

        // Reset with a read request, then reset with a write attempt of 77@0.
        step(1'b1, 1'b1, 1'b0, 16'd0, 16'd0);
        check("reset_edge1", 16'h0000);
        step(1'b1, 1'b0, 1'b0, 16'd0, 16'd77);
        check("reset_edge2_write_blocked", 16'h0000);

        // Load program; output must hold zero throughout the writes.
        for (int i = 0; i < 12; i++) begin
            step(1'b0, 1'b0, 1'b0, wa[i], wd[i]);
            if (i == 0 || i == 11) check($sformatf("hold_during_write_%0d", i), 16'h0000);
        end

        // Back-to-back readback.
        for (int i = 0; i < 12; i++) begin
            step(1'b0, 1'b1, 1'b0, wa[i], 16'd0);
            check($sformatf("readback_addr%0d", wa[i]), wd[i]);
        end

        // Word 0 must not have been written by the write issued under reset.
        step(1'b0, 1'b1, 1'b0, 16'd0, 16'd0);
        check("mem0_untouched_by_reset_write", 16'd12);

        // Disabled write of 999@10 is ignored; output holds.
        step(1'b0, 1'b0, 1'b1, 16'd10, 16'd999);
        check("disabled_write_hold", 16'd12);
        step(1'b0, 1'b1, 1'b0, 16'd10, 16'd0);
        check("read10_after_disabled_write", 16'd34);
        step(1'b0, 1'b1, 1'b1, 16'd20, 16'd0);
        check("disabled_read_hold_a", 16'd34);
        step(1'b0, 1'b1, 1'b1, 16'd30, 16'd0);
        check("disabled_read_hold_b", 16'd34);

        // Out-of-range write must not alias onto word 44.
        step(1'b0, 1'b0, 1'b0, 16'd300, 16'd4321);
        check("oor_write_hold", 16'd34);
        step(1'b0, 1'b1, 1'b0, 16'd44, 16'd0);
        check("read44_no_alias", 16'h0000);
        step(1'b0, 1'b1, 1'b0, 16'd10, 16'd0);
        check("read10_before_oor", 16'd34);
        step(1'b0, 1'b1, 1'b0, 16'd300, 16'd0);
        check("read300_zero", 16'h0000);
        step(1'b0, 1'b1, 1'b0, 16'd20, 16'd0);
        check("read20_before_ffff", 16'd56);
        step(1'b0, 1'b1, 1'b0, 16'hFFFF, 16'd0);
        check("readFFFF_zero", 16'h0000);

        // Reset in the middle of reads; contents survive.
        step(1'b0, 1'b1, 1'b0, 16'd30, 16'd0);
        check("read30_before_reset", 16'd78);
        step(1'b1, 1'b1, 1'b0, 16'd40, 16'd0);
        check("midrun_reset_zero", 16'h0000);
        step(1'b0, 1'b1, 1'b0, 16'd200, 16'd0);
        check("read200_after_reset", 16'd9012);

        // Write then read same address on the next edge; mode switch needs no turnaround.
        step(1'b0, 1'b1, 1'b0, 16'd50, 16'd0);
        check("read50", 16'd1234);
        step(1'b0, 1'b0, 1'b0, 16'd5, 16'hBEEF);
        check("no_write_through", 16'd1234);
        step(1'b0, 1'b1, 1'b0, 16'd5, 16'd0);
        check("read5_new_word", 16'hBEEF);
        step(1'b0, 1'b1, 1'b0, 16'd44, 16'd0);
        check("read44_still_zero", 16'h0000);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule : tb_instr_mem
